cfa_wb_streamer: RTL and testbench
==================================

# cfa_wb_streamer

Downstream stage of the CFA demosaic block. After the demosaic has filled the red, green and blue planes, this block reads them back in row-major order and applies a per-channel white-balance gain with rounding and saturation. It emits one RGB pixel per cycle on a valid/ready stream with frame and line markers. `start` is normally driven by the demosaic's `done`.

## Interface
- `ADDR_W`, 17: plane address width.
- `PIX_W`, 12: pixel width.
- `GAIN_W`, 10: gain width, unsigned Q2.8 (256 = 1.0).
- `FIFO_D`, 4: output FIFO depth.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous assert, active-low.
- `start` in 1: one-cycle frame start pulse.
- `rowMax` in 11: frame rows.
- `colMax` in 11: frame columns.
- `gainR`, `gainG`, `gainB` in GAIN_W each: channel gains, sampled at accepted `start`.
- `readAddress` out ADDR_W: plane read address, shared by all three planes.
- `redRead`, `greenRead`, `blueRead` in PIX_W each: plane data, valid one cycle after `readAddress` (synchronous RAM).
- `out_valid` out 1, `out_ready` in 1: stream handshake.
- `out_red`, `out_green`, `out_blue` out PIX_W each: balanced pixel.
- `out_sof`, `out_eol`, `out_eof` out 1 each: first pixel, last pixel of row, last pixel of frame.
- `busy` out 1: frame in progress.
- `done` out 1: one-cycle pulse when the frame is complete.

## Operation
- FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start` with `rowMax`≠0 and `colMax`≠0 latches dims and gains, zeroes the address/row/col counters, and goes to RUN.
  - `start` with either dim 0 goes to DONE with no pixels.
- RUN: issues one read per cycle while credit allows.
  - Credit condition: FIFO occupancy + in-flight reads + in-flight gain-stage entries < `FIFO_D`.
  - Address is row*colMax+col, incrementing 0..N-1 with N = rowMax*colMax.
  - Column counter wraps at colMax-1 and increments the row counter.
  - After issuing address N-1, go to DRAIN.
- DRAIN: wait until the pipeline and FIFO are empty and the last pixel has handshaken, then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `start` outside IDLE is ignored. Gain or dim input changes mid-frame have no effect.
- Per channel: p = pix*gain (22 bits); q = (p+128)>>8; out = min(q, 4095).
- `sof`/`eol`/`eof` flags are computed at read issue and carried alongside the data through the pipeline and FIFO.
- `busy` = 1 in RUN and DRAIN.

## Timing
- Pipeline:
  - Edge E0 samples `start`.
  - `readAddress`=0 during E0..E1.
  - Data is captured into the gain register at E2.
  - The FIFO is written at E3.
  - `out_valid` is high from E3 onward.
- Throughput is 1 pixel/cycle with `out_ready` held at 1; a 7x7 frame has its last handshake at E3+48.
- `done` is high in the cycle after the last handshake.
- Stream rules:
  - While `out_valid` && !`out_ready`, data and flags are held stable.
  - `out_valid` never drops without a handshake.
- FIFO full: read issue stalls and `readAddress` holds its last value. No pixel is lost or duplicated.
- Simultaneous FIFO push and pop when full: the push is legal only because credit accounting guarantees a free slot.
- Reset values:
  - `readAddress`=0, all `out_*`=0, `busy`=0, `done`=0.
  - FIFO empty, FSM in IDLE.
- Reset mid-frame: immediate clear, no `done`. The next `start` begins at address 0.

## Structure
- Shared package `cfa_pkg` holds:
  - `PIX_W`, `ADDR_W`, `GAIN_ONE`=256, `PIX_MAX`=4095.
  - `wb_state_t` enum (IDLE/RUN/DRAIN/DONE).
  - Pixel-with-flags struct (3×PIX_W + 3 flags).
- One sub-module, `cfa_out_fifo`: FIFO_D-entry synchronous FIFO with occupancy count and asynchronous active-low reset, `rst`.

## Test plan
- 7x7, all gains 256, `out_ready`=1, planes hold value = address -> 49 pixels equal to address; first `out_valid` at E3; `sof` on pixel 0; `eol` on pixels 6,13,…,48; `eof` on 48; `done` one cycle after the last handshake.
- Arithmetic: red 4000 with gainR 512 -> 4095. Green 1000 with gainG 384 -> 1500. Blue 3 with gainB 128 -> 2.
- Backpressure: `out_ready` low for 10 cycles mid-frame, then randomized -> `readAddress` stalls once 4 entries are outstanding; outputs are stable while stalled; the sequence is complete and in order.
- `rowMax`=0 -> `done` pulses one cycle after `start`; `out_valid` never asserts; `readAddress` stays 0.
- `rst` low after pixel 20 -> all outputs 0 in the same cycle. After release, a new `start` streams from address 0 with `sof`.
- Second `start` and a gain change mid-frame -> ignored; the frame finishes with the original gains and exactly one `done`.

Source files
------------

// File: rtl/cfa_pkg.sv
// Shared types and constants for the CFA white-balance streamer.
package cfa_pkg;

   localparam int ADDR_W     = 17;
   localparam int PIX_W      = 12;
   localparam int GAIN_W     = 10;
   localparam int DIM_W      = 11;
   localparam int FIFO_D_DEF = 4;
   localparam int GAIN_ONE   = 256;
   localparam int GAIN_FRAC  = 8;
   localparam int PIX_MAX    = 4095;
   localparam int PROD_W     = PIX_W + GAIN_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wb_state_t;

   typedef struct packed {
      logic [PIX_W-1:0] red;
      logic [PIX_W-1:0] green;
      logic [PIX_W-1:0] blue;
      logic             sof;
      logic             eol;
      logic             eof;
   } pix_t;

   // Worst case 4095*1023 + 128 still fits in PROD_W bits, so no guard bit is needed.
   function automatic logic [PIX_W-1:0] wb_scale(input logic [PIX_W-1:0]  pix,
                                                 input logic [GAIN_W-1:0] gain);
      logic [PROD_W-1:0]           prod;
      logic [PROD_W-GAIN_FRAC-1:0] q;
      prod = PROD_W'(pix) * PROD_W'(gain) + PROD_W'(GAIN_ONE / 2);
      q    = prod[PROD_W-1:GAIN_FRAC];
      return (q > (PROD_W-GAIN_FRAC)'(PIX_MAX)) ? PIX_W'(PIX_MAX) : q[PIX_W-1:0];
   endfunction

endpackage

// File: rtl/cfa_out_fifo.sv
// Small synchronous output FIFO of flagged pixels with an occupancy count.
module cfa_out_fifo
   import cfa_pkg::*;
#(
   parameter int DEPTH = FIFO_D_DEF
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  pix_t                           push_data,
   input  logic                           pop,
   output pix_t                           head,
   output logic [$clog2(DEPTH+1)-1:0]     count,
   output logic                           empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   pix_t             mem_q [DEPTH];
   pix_t             mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             full, do_push, do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_W'(DEPTH));
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only alongside a pop that frees the slot.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/cfa_wb_streamer.sv
// Reads demosaiced RGB planes in raster order, applies white-balance gains and streams pixels out.
// state | meaning
// IDLE  | waiting for start, dims/gains not yet latched
// RUN   | issuing one plane read per cycle while FIFO credit allows
// DRAIN | all reads issued, waiting for pipeline and FIFO to empty
// DONE  | one-cycle done pulse
module cfa_wb_streamer
   import cfa_pkg::*;
#(
   parameter int FIFO_D = FIFO_D_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIM_W-1:0]  rowMax,
   input  logic [DIM_W-1:0]  colMax,
   input  logic [GAIN_W-1:0] gainR,
   input  logic [GAIN_W-1:0] gainG,
   input  logic [GAIN_W-1:0] gainB,
   output logic [ADDR_W-1:0] readAddress,
   input  logic [PIX_W-1:0]  redRead,
   input  logic [PIX_W-1:0]  greenRead,
   input  logic [PIX_W-1:0]  blueRead,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PIX_W-1:0]  out_red,
   output logic [PIX_W-1:0]  out_green,
   output logic [PIX_W-1:0]  out_blue,
   output logic              out_sof,
   output logic              out_eol,
   output logic              out_eof,
   output logic              busy,
   output logic              done
);
   localparam int CNT_W = $clog2(FIFO_D + 1);

   wb_state_t         state_q, state_d;
   logic [DIM_W-1:0]  rows_q, rows_d, cols_q, cols_d;
   logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
   logic [GAIN_W-1:0] gain_r_q, gain_r_d, gain_g_q, gain_g_d, gain_b_q, gain_b_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_vld_q, rd_vld_d;
   logic [2:0]        rd_flags_q, rd_flags_d;
   logic              gain_vld_q, gain_vld_d;
   pix_t              gain_q, gain_d;

   logic              issue, last_pix, credit_ok, pop, fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic [CNT_W:0]    credit_used;
   pix_t              fifo_head;

   // Every entry already in flight must have a guaranteed FIFO slot.
   assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(rd_vld_q) + (CNT_W+1)'(gain_vld_q);
   assign credit_ok   = credit_used < (CNT_W+1)'(FIFO_D);
   assign last_pix    = (row_q == rows_q - DIM_W'(1)) && (col_q == cols_q - DIM_W'(1));

   always_comb begin
      state_d  = state_q;
      rows_d   = rows_q;
      cols_d   = cols_q;
      row_d    = row_q;
      col_d    = col_q;
      addr_d   = addr_q;
      gain_r_d = gain_r_q;
      gain_g_d = gain_g_q;
      gain_b_d = gain_b_q;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               addr_d = '0;
               row_d  = '0;
               col_d  = '0;
               if (rowMax != '0 && colMax != '0) begin
                  rows_d   = rowMax;
                  cols_d   = colMax;
                  gain_r_d = gainR;
                  gain_g_d = gainG;
                  gain_b_d = gainB;
                  state_d  = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (last_pix) begin
                  state_d = DRAIN;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  if (col_q == cols_q - DIM_W'(1)) begin
                     col_d = '0;
                     row_d = row_q + DIM_W'(1);
                  end else begin
                     col_d = col_q + DIM_W'(1);
                  end
               end
            end
         end
         DRAIN: begin
            if (!rd_vld_q && !gain_vld_q &&
                (fifo_count == '0 || (fifo_count == CNT_W'(1) && pop))) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      rd_vld_d   = issue;
      rd_flags_d = rd_flags_q;
      if (issue) begin
         rd_flags_d = {(row_q == '0) && (col_q == '0), col_q == cols_q - DIM_W'(1), last_pix};
      end
      gain_vld_d = rd_vld_q;
      gain_d     = gain_q;
      if (rd_vld_q) begin
         gain_d.red   = wb_scale(redRead,   gain_r_q);
         gain_d.green = wb_scale(greenRead, gain_g_q);
         gain_d.blue  = wb_scale(blueRead,  gain_b_q);
         gain_d.sof   = rd_flags_q[2];
         gain_d.eol   = rd_flags_q[1];
         gain_d.eof   = rd_flags_q[0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         rows_q     <= '0;
         cols_q     <= '0;
         row_q      <= '0;
         col_q      <= '0;
         addr_q     <= '0;
         gain_r_q   <= '0;
         gain_g_q   <= '0;
         gain_b_q   <= '0;
         rd_vld_q   <= 1'b0;
         rd_flags_q <= '0;
         gain_vld_q <= 1'b0;
         gain_q     <= '0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         cols_q     <= cols_d;
         row_q      <= row_d;
         col_q      <= col_d;
         addr_q     <= addr_d;
         gain_r_q   <= gain_r_d;
         gain_g_q   <= gain_g_d;
         gain_b_q   <= gain_b_d;
         rd_vld_q   <= rd_vld_d;
         rd_flags_q <= rd_flags_d;
         gain_vld_q <= gain_vld_d;
         gain_q     <= gain_d;
      end
   end

   cfa_out_fifo #(.DEPTH(FIFO_D)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (gain_vld_q),
      .push_data (gain_q),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

   assign readAddress = addr_q;
   assign out_valid   = !fifo_empty;
   assign pop         = out_valid && out_ready;
   assign out_red     = out_valid ? fifo_head.red   : '0;
   assign out_green   = out_valid ? fifo_head.green : '0;
   assign out_blue    = out_valid ? fifo_head.blue  : '0;
   assign out_sof     = out_valid && fifo_head.sof;
   assign out_eol     = out_valid && fifo_head.eol;
   assign out_eof     = out_valid && fifo_head.eof;
   assign busy        = (state_q == RUN) || (state_q == DRAIN);
   assign done        = (state_q == DONE);

endmodule

// File: tb/tb_cfa_wb_streamer.sv
// Randomized bench for cfa_wb_streamer against a raster-order white-balance reference model.
module tb_cfa_wb_streamer;

   logic        clk;
   logic        rst;
   logic        start;
   logic [10:0] rowMax, colMax;
   logic [9:0]  gainR, gainG, gainB;
   logic [16:0] readAddress;
   logic [11:0] redRead, greenRead, blueRead;
   logic        out_valid, out_ready;
   logic [11:0] out_red, out_green, out_blue;
   logic        out_sof, out_eol, out_eof, busy, done;

   logic [11:0] red_mem   [4096];
   logic [11:0] green_mem [4096];
   logic [11:0] blue_mem  [4096];

   logic [38:0] rx_q [$];
   logic [38:0] exp_q [$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int hs_cnt, first_valid_cyc, last_hs_cyc, done_cnt, done_cyc, valid_seen;
   logic        prev_stall = 1'b0;
   logic [38:0] prev_pix = '0;

   cfa_wb_streamer dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .rowMax      (rowMax),
      .colMax      (colMax),
      .gainR       (gainR),
      .gainG       (gainG),
      .gainB       (gainB),
      .readAddress (readAddress),
      .redRead     (redRead),
      .greenRead   (greenRead),
      .blueRead    (blueRead),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_red     (out_red),
      .out_green   (out_green),
      .out_blue    (out_blue),
      .out_sof     (out_sof),
      .out_eol     (out_eol),
      .out_eof     (out_eof),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous plane RAMs: data valid one cycle after the address.
   always @(posedge clk) begin
      redRead   <= red_mem[readAddress[11:0]];
      greenRead <= green_mem[readAddress[11:0]];
      blueRead  <= blue_mem[readAddress[11:0]];
   end

   always @(negedge clk) begin
      logic [38:0] cur;
      cur = {out_red, out_green, out_blue, out_sof, out_eol, out_eof};
      if (rst) begin
         if (prev_stall) begin
            tests++;
            if (out_valid !== 1'b1 || cur !== prev_pix) begin
               fails++;
               $display("FAIL stall_stable: valid %b data %h, required valid 1 data %h", out_valid, cur, prev_pix);
            end
         end
         if (out_valid) valid_seen++;
         if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (out_valid && out_ready) begin
            rx_q.push_back(cur);
            hs_cnt++;
            last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_stall = out_valid && !out_ready;
         prev_pix   = cur;
      end else begin
         prev_stall = 1'b0;
      end
   end

   function automatic logic [11:0] scale(input int pix, input int gain);
      int q;
      q = (pix * gain + 128) / 256;
      if (q > 4095) q = 4095;
      return 12'(q);
   endfunction

   task automatic fill_identity();
      for (int a = 0; a < 4096; a++) begin
         red_mem[a]   = 12'(a);
         green_mem[a] = 12'(a);
         blue_mem[a]  = 12'(a);
      end
   endtask

   task automatic fill_random();
      for (int a = 0; a < 4096; a++) begin
         red_mem[a]   = 12'($urandom_range(0, 4095));
         green_mem[a] = 12'($urandom_range(0, 4095));
         blue_mem[a]  = 12'($urandom_range(0, 4095));
      end
   endtask

   task automatic build_expected(input int rows, input int cols, input int gr, input int gg, input int gb);
      int n;
      n = rows * cols;
      exp_q.delete();
      for (int a = 0; a < n; a++) begin
         exp_q.push_back({scale(int'(red_mem[a]), gr), scale(int'(green_mem[a]), gg),
                          scale(int'(blue_mem[a]), gb),
                          a == 0, (a % cols) == cols - 1, a == n - 1});
      end
   endtask

   task automatic clear_mon();
      rx_q.delete();
      hs_cnt          = 0;
      first_valid_cyc = -1;
      last_hs_cyc     = -1;
      done_cnt        = 0;
      done_cyc        = -1;
      valid_seen      = 0;
   endtask

   task automatic start_frame(input int rows, input int cols, input int gr, input int gg, input int gb,
                              output int k0);
      @(posedge clk); #1;
      clear_mon();
      rowMax = 11'(rows);
      colMax = 11'(cols);
      gainR  = 10'(gr);
      gainG  = 10'(gg);
      gainB  = 10'(gb);
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      k0     = cyc;
   endtask

   task automatic wait_done(input string name, input int budget, input logic rand_ready);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         n++;
      end
      out_ready = 1'b1;
      tests++;
      if (done_cnt == 0) begin
         fails++;
         $display("FAIL %s done_timeout: done count %0d after %0d cycles, required 1", name, done_cnt, budget);
      end
      repeat (3) @(posedge clk); #1;
   endtask

   task automatic check_frame(input string name);
      tests++;
      if (rx_q.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s pixel_count: got %0d, required %0d", name, rx_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         tests++;
         if (rx_q[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL %s pixel %0d: got %h, required %h", name, i, rx_q[i], exp_q[i]);
         end
      end
      tests++;
      if (done_cnt != 1) begin
         fails++;
         $display("FAIL %s done_count: got %0d, required 1", name, done_cnt);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      tests++;
      if ({readAddress, out_valid, out_red, out_green, out_blue, out_sof, out_eol, out_eof, busy, done} !== '0) begin
         fails++;
         $display("FAIL reset_state: addr %0d valid %b rgb %0d/%0d/%0d flags %b%b%b busy %b done %b, required all 0",
                  readAddress, out_valid, out_red, out_green, out_blue, out_sof, out_eol, out_eof, busy, done);
      end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_identity();
      int k0;
      fill_identity();
      out_ready = 1'b1;
      start_frame(7, 7, 256, 256, 256, k0);
      @(negedge clk);
      tests++;
      if (readAddress !== 17'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL identity_e0: addr %0d busy %b, required addr 0 busy 1", readAddress, busy);
      end
      wait_done("identity", 200, 1'b0);
      build_expected(7, 7, 256, 256, 256);
      check_frame("identity");
      tests++;
      if (first_valid_cyc != k0 + 3) begin
         fails++;
         $display("FAIL identity_first_valid: got E%0d, required E3", first_valid_cyc - k0);
      end
      tests++;
      if (last_hs_cyc != k0 + 51) begin
         fails++;
         $display("FAIL identity_last_hs: got E%0d, required E51", last_hs_cyc - k0);
      end
      tests++;
      if (done_cyc != k0 + 52) begin
         fails++;
         $display("FAIL identity_done_time: got E%0d, required E52", done_cyc - k0);
      end
   endtask

   task automatic test_arith();
      int k0;
      fill_random();
      red_mem[0]   = 12'd4000;
      green_mem[0] = 12'd1000;
      blue_mem[0]  = 12'd3;
      start_frame(1, 3, 512, 384, 128, k0);
      wait_done("arith", 100, 1'b0);
      build_expected(1, 3, 512, 384, 128);
      check_frame("arith");
      tests++;
      if (rx_q.size() == 0 || rx_q[0] !== {12'd4095, 12'd1500, 12'd2, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL arith_pixel0: got %h, required rgb 4095/1500/2 sof", rx_q.size() > 0 ? rx_q[0] : 39'h0);
      end
   endtask

   task automatic test_backpressure();
      int k0, n, h;
      logic [16:0] held;
      int gr, gg, gb;
      fill_random();
      gr = $urandom_range(0, 1023);
      gg = $urandom_range(0, 1023);
      gb = $urandom_range(0, 1023);
      out_ready = 1'b1;
      start_frame(6, 8, gr, gg, gb, k0);
      n = 0;
      while (hs_cnt < 10 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      out_ready = 1'b0;
      repeat (6) @(posedge clk); #1;
      h    = hs_cnt;
      held = readAddress;
      tests++;
      if (held !== 17'(h + 4)) begin
         fails++;
         $display("FAIL bp_stall_addr: got %0d with %0d handshakes, required %0d", held, h, h + 4);
      end
      repeat (4) @(posedge clk); #1;
      tests++;
      if (readAddress !== held || hs_cnt != h) begin
         fails++;
         $display("FAIL bp_addr_hold: addr %0d hs %0d, required addr %0d hs %0d", readAddress, hs_cnt, held, h);
      end
      wait_done("backpressure", 600, 1'b1);
      build_expected(6, 8, gr, gg, gb);
      check_frame("backpressure");
   endtask

   task automatic test_random_frames();
      int k0, rows, cols, gr, gg, gb;
      for (int f = 0; f < 3; f++) begin
         fill_random();
         rows = $urandom_range(1, 5);
         cols = $urandom_range(1, 9);
         gr   = $urandom_range(0, 1023);
         gg   = $urandom_range(0, 1023);
         gb   = $urandom_range(0, 1023);
         start_frame(rows, cols, gr, gg, gb, k0);
         wait_done("random", 600, 1'b1);
         build_expected(rows, cols, gr, gg, gb);
         check_frame("random");
      end
   endtask

   task automatic test_zero_dim();
      int k0;
      start_frame(0, 5, 256, 256, 256, k0);
      @(negedge clk);
      tests++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         fails++;
         $display("FAIL zero_done_pulse: done %b busy %b, required done 1 busy 0", done, busy);
      end
      @(negedge clk);
      tests++;
      if (done !== 1'b0) begin
         fails++;
         $display("FAIL zero_done_width: done %b, required 0", done);
      end
      repeat (8) @(posedge clk); #1;
      tests++;
      if (valid_seen != 0 || readAddress !== 17'd0 || done_cnt != 1) begin
         fails++;
         $display("FAIL zero_quiet: valid cycles %0d addr %0d dones %0d, required 0/0/1", valid_seen, readAddress, done_cnt);
      end
   endtask

   task automatic test_reset_midframe();
      int k0, n;
      fill_identity();
      out_ready = 1'b1;
      start_frame(7, 7, 256, 256, 256, k0);
      n = 0;
      while (hs_cnt < 21 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      rst = 1'b0;
      #1;
      tests++;
      if ({readAddress, out_valid, out_red, out_green, out_blue, out_sof, out_eol, out_eof, busy, done} !== '0) begin
         fails++;
         $display("FAIL midreset_clear: addr %0d valid %b rgb %0d/%0d/%0d busy %b, required all 0",
                  readAddress, out_valid, out_red, out_green, out_blue, busy);
      end
      repeat (3) @(posedge clk); #1;
      tests++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL midreset_no_done: dones %0d busy %b, required 0/0", done_cnt, busy);
      end
      rst = 1'b1;
      start_frame(7, 7, 256, 256, 256, k0);
      wait_done("after_reset", 200, 1'b0);
      build_expected(7, 7, 256, 256, 256);
      check_frame("after_reset");
      tests++;
      if (first_valid_cyc != k0 + 3) begin
         fails++;
         $display("FAIL after_reset_first_valid: got E%0d, required E3", first_valid_cyc - k0);
      end
   endtask

   task automatic test_ignore_midframe();
      int k0, gr, gg, gb;
      fill_random();
      gr = $urandom_range(0, 1023);
      gg = $urandom_range(0, 1023);
      gb = $urandom_range(0, 1023);
      start_frame(5, 5, gr, gg, gb, k0);
      repeat (6) @(posedge clk); #1;
      start  = 1'b1;
      rowMax = 11'd3;
      colMax = 11'd2;
      gainR  = 10'(gr ^ 10'h155);
      gainG  = 10'(gg ^ 10'h0AA);
      gainB  = 10'(gb ^ 10'h3FF);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done("ignore", 300, 1'b1);
      repeat (5) @(posedge clk); #1;
      build_expected(5, 5, gr, gg, gb);
      check_frame("ignore");
   endtask

   initial begin
      rst       = 1'b0;
      start     = 1'b0;
      rowMax    = '0;
      colMax    = '0;
      gainR     = '0;
      gainG     = '0;
      gainB     = '0;
      out_ready = 1'b1;
      fill_identity();
      clear_mon();
      test_reset();
      test_identity();
      test_arith();
      test_backpressure();
      test_random_frames();
      test_zero_dim();
      test_reset_midframe();
      test_ignore_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
